// File: rtl/weight_fifo.sv
// weight_fifo: row buffer for systolic-array weights.
// One MUL_SIZE-lane row is written per cycle on a valid/ready port; rows pop
// in FIFO order on rd_en_i and come back registered with a one-cycle valid_o
// pulse, plus a tile_last_o marker on the last row of each MUL_SIZE-row tile.
// Optional feature macro: WEIGHT_FIFO_ERR_EN adds sticky overflow_o/underflow_o.

// One lane of the row storage: DATA_W-bit memory column plus its output register.
module weight_fifo_lane #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage column; left unreset so it maps onto plain RAM/flops.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read; holds its value between pops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module weight_fifo #(
  parameter int MUL_SIZE = 16,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 2*MUL_SIZE
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_valid_i,
  input  logic [MUL_SIZE*DATA_W-1:0] wr_data_i,
  output logic                       wr_ready_o,
  input  logic                       rd_en_i,
  input  logic                       flush_i,
  output logic [MUL_SIZE*DATA_W-1:0] rd_data_o,
  output logic                       valid_o,
  output logic                       tile_last_o,
  output logic                       tile_avail_o,
  output logic [$clog2(DEPTH):0]     count_o
`ifdef WEIGHT_FIFO_ERR_EN
  ,
  output logic                       overflow_o,
  output logic                       underflow_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;

  logic [MUL_SIZE-1:0][DATA_W-1:0] wr_row, rd_row;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [RW-1:0] row_cntr_q, row_cntr_d;
  logic          valid_q, valid_d, tile_last_q, tile_last_d;
  logic          push, pop;

  assign wr_row     = wr_data_i;
  assign rd_data_o  = rd_row;
  assign wr_ready_o = (count_q != CW'(DEPTH));

  // A flush on the same edge drops any push/pop; reset gates the memory write.
  assign push = rst_ni & ~flush_i & wr_valid_i & wr_ready_o;
  assign pop  = rst_ni & ~flush_i & rd_en_i & (count_q != '0);

  // Next-state for pointers, occupancy, tile row counter and output flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    row_cntr_d  = row_cntr_q;
    valid_d     = 1'b0;
    tile_last_d = 1'b0;
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      row_cntr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + AW'(1);
        row_cntr_d  = (row_cntr_q == RW'(MUL_SIZE-1)) ? '0 : row_cntr_q + RW'(1);
        tile_last_d = (row_cntr_q == RW'(MUL_SIZE-1));
      end
      valid_d = pop;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      row_cntr_q  <= '0;
      valid_q     <= 1'b0;
      tile_last_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      row_cntr_q  <= row_cntr_d;
      valid_q     <= valid_d;
      tile_last_q <= tile_last_d;
    end
  end

  // Lanes are independent columns; data passes bit-exact.
  for (genvar l = 0; l < MUL_SIZE; l++) begin : g_lane
    weight_fifo_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_row[l]),
      .re_i    (pop),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_row[l])
    );
  end

  assign valid_o      = valid_q;
  assign tile_last_o  = tile_last_q;
  assign tile_avail_o = (count_q >= CW'(MUL_SIZE));
  assign count_o      = count_q;

`ifdef WEIGHT_FIFO_ERR_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  // Sticky error flags; cleared only by reset or flush.
  always_comb begin
    ovf_d = ovf_q | (wr_valid_i & ~wr_ready_o);
    unf_d = unf_q | (rd_en_i & (count_q == '0));
    if (flush_i) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
`endif
endmodule

// File: tb/tb_weight_fifo.sv
// Self-checking bench for weight_fifo (MUL_SIZE=4, DATA_W=8, DEPTH=8).
// A queue model tracks stored rows; each modelled pop pushes the expected
// row/tile_last onto a scoreboard that the negedge monitor pops on valid_o.
module tb_weight_fifo;
  localparam int MS = 4;
  localparam int DW = 8;
  localparam int D  = 8;
  localparam int RWD = MS*DW;

  logic           clk = 1'b0;
  logic           rst_ni = 1'b1;
  logic           wr_valid_i = 1'b0;
  logic [RWD-1:0] wr_data_i = '0;
  logic           wr_ready_o;
  logic           rd_en_i = 1'b0;
  logic           flush_i = 1'b0;
  logic [RWD-1:0] rd_data_o;
  logic           valid_o, tile_last_o, tile_avail_o;
  logic [3:0]     count_o;
`ifdef WEIGHT_FIFO_ERR_EN
  logic           overflow_o, underflow_o;
`endif

  weight_fifo #(.MUL_SIZE(MS), .DATA_W(DW), .DEPTH(D)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o), .rd_en_i(rd_en_i), .flush_i(flush_i),
    .rd_data_o(rd_data_o), .valid_o(valid_o), .tile_last_o(tile_last_o),
    .tile_avail_o(tile_avail_o), .count_o(count_o)
`ifdef WEIGHT_FIFO_ERR_EN
    , .overflow_o(overflow_o), .underflow_o(underflow_o)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed { logic [RWD-1:0] d; logic last; } exp_t;
  logic [RWD-1:0] mq[$];
  exp_t           eq[$];
  exp_t           e;
  int             rowcnt = 0;
  bit             m_pop, m_push;

  // Reference model: sees inputs exactly as the DUT does at each edge.
  always @(posedge clk) begin
    if (rst_ni) begin
      if (flush_i) begin
        mq.delete();
        rowcnt = 0;
      end else begin
        m_pop  = rd_en_i && (mq.size() != 0);
        m_push = wr_valid_i && (mq.size() != D);
        if (m_pop) begin
          eq.push_back('{d: mq.pop_front(), last: (rowcnt == MS-1)});
          rowcnt = (rowcnt + 1) % MS;
        end
        if (m_push) mq.push_back(wr_data_i);
      end
    end
  end

  always @(negedge rst_ni) begin
    mq.delete();
    eq.delete();
    rowcnt = 0;
  end

  // Monitor: compares outputs against the scoreboard mid-cycle.
  always @(negedge clk) begin
    n_vec++;
    if (valid_o !== (eq.size() != 0)) begin
      n_err++;
      $display("FAIL mon_valid t=%0t got %b want %b", $time, valid_o, eq.size() != 0);
    end
    if (eq.size() != 0) begin
      e = eq.pop_front();
      if (valid_o === 1'b1) begin
        n_vec++;
        if (rd_data_o !== e.d) begin
          n_err++;
          $display("FAIL mon_data t=%0t got %h want %h", $time, rd_data_o, e.d);
        end
        n_vec++;
        if (tile_last_o !== e.last) begin
          n_err++;
          $display("FAIL mon_last t=%0t got %b want %b", $time, tile_last_o, e.last);
        end
      end
    end else begin
      n_vec++;
      if (tile_last_o !== 1'b0) begin
        n_err++;
        $display("FAIL mon_last_idle t=%0t got %b want 0", $time, tile_last_o);
      end
    end
    n_vec++;
    if (count_o !== 4'(mq.size()) || wr_ready_o !== (mq.size() != D) ||
        tile_avail_o !== (mq.size() >= MS)) begin
      n_err++;
      $display("FAIL mon_occ t=%0t got cnt=%0d rdy=%b av=%b want cnt=%0d", $time,
               count_o, wr_ready_o, tile_avail_o, mq.size());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [RWD-1:0] d, input bit r, input bit f);
    wr_valid_i = v; wr_data_i = d; rd_en_i = r; flush_i = f;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < D + 2 && mq.size() != 0; i++) drive(0, '0, 1, 0);
    drive(0, '0, 0, 0);
  endtask

  task automatic test_reset();
    #1 rst_ni = 1'b0;
    #1;
    n_vec++;
    if (valid_o !== 1'b0 || tile_last_o !== 1'b0 || count_o !== 4'd0 ||
        rd_data_o !== '0 || tile_avail_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_vals got v=%b l=%b c=%0d d=%h av=%b want all 0",
               valid_o, tile_last_o, count_o, rd_data_o, tile_avail_o);
    end
    n_vec++;
    if (wr_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready got %b want 1", wr_ready_o);
    end
    tick(); tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [RWD-1:0] rows [4];
    rows[0] = 32'h04030201; rows[1] = 32'h08070605;
    rows[2] = 32'h0C0B0A09; rows[3] = 32'h100F0E0D;
    for (int i = 0; i < 4; i++) drive(1, rows[i], 0, 0);
    drive(0, '0, 0, 0);
    n_vec++;
    if (count_o !== 4'd4 || tile_avail_o !== 1'b1) begin
      n_err++;
      $display("FAIL basic_fill got cnt=%0d av=%b want 4 1", count_o, tile_avail_o);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 1, 0);
      n_vec++;
      if (valid_o !== 1'b1 || rd_data_o !== rows[i] || tile_last_o !== (i == 3)) begin
        n_err++;
        $display("FAIL basic_pop%0d got v=%b d=%h l=%b want 1 %h %b", i,
                 valid_o, rd_data_o, tile_last_o, rows[i], i == 3);
      end
    end
    drive(0, '0, 0, 0);
    n_vec++;
    if (count_o !== 4'd0 || valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL basic_end got cnt=%0d v=%b want 0 0", count_o, valid_o);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < D; i++) drive(1, 32'hA0A0A000 + i, 0, 0);
    n_vec++;
    if (wr_ready_o !== 1'b0 || count_o !== 4'd8) begin
      n_err++;
      $display("FAIL full_state got rdy=%b cnt=%0d want 0 8", wr_ready_o, count_o);
    end
    drive(1, 32'hDEAD0009, 0, 0);
    n_vec++;
    if (count_o !== 4'd8) begin
      n_err++;
      $display("FAIL full_holdoff got cnt=%0d want 8", count_o);
    end
    drive(1, 32'hDEAD0009, 1, 0);
    n_vec++;
    if (wr_ready_o !== 1'b1 || count_o !== 4'd7) begin
      n_err++;
      $display("FAIL full_nobypass got rdy=%b cnt=%0d want 1 7", wr_ready_o, count_o);
    end
    drive(1, 32'hDEAD0009, 0, 0);
    n_vec++;
    if (count_o !== 4'd8) begin
      n_err++;
      $display("FAIL full_accept9 got cnt=%0d want 8", count_o);
    end
    drain();
  endtask

  task automatic test_empty_same_cycle();
    drive(1, 32'h5A5A1234, 1, 0);
    n_vec++;
    if (valid_o !== 1'b0 || count_o !== 4'd1) begin
      n_err++;
      $display("FAIL empty_rd got v=%b cnt=%0d want 0 1", valid_o, count_o);
    end
    drive(0, '0, 1, 0);
    n_vec++;
    if (valid_o !== 1'b1 || rd_data_o !== 32'h5A5A1234 || count_o !== 4'd0) begin
      n_err++;
      $display("FAIL empty_next got v=%b d=%h cnt=%0d want 1 5a5a1234 0",
               valid_o, rd_data_o, count_o);
    end
    drive(0, '0, 0, 0);
  endtask

  task automatic test_back_to_back();
    drive(0, '0, 0, 1);
    drive(1, 32'hC0DE0000, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      drive(1, 32'hC0DE0000 + k, 1, 0);
      n_vec++;
      if (count_o !== 4'd1 || valid_o !== 1'b1 || rd_data_o !== 32'hC0DE0000 + k - 1 ||
          tile_last_o !== (k % 4 == 0)) begin
        n_err++;
        $display("FAIL stream_pop%0d got cnt=%0d v=%b d=%h l=%b want 1 1 %h %b", k,
                 count_o, valid_o, rd_data_o, tile_last_o, 32'hC0DE0000 + k - 1, k % 4 == 0);
      end
    end
    drain();
  endtask

  task automatic test_flush();
    drive(0, '0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 32'hF1000000 + i, 0, 0);
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 0);
    drive(0, '0, 1, 1);
    n_vec++;
    if (valid_o !== 1'b0 || count_o !== 4'd0 || tile_last_o !== 1'b0 ||
        rd_data_o !== 32'hF1000001) begin
      n_err++;
      $display("FAIL flush_state got v=%b cnt=%0d l=%b d=%h want 0 0 0 f1000001",
               valid_o, count_o, tile_last_o, rd_data_o);
    end
    for (int i = 0; i < 4; i++) drive(1, 32'hF2000000 + i, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 1, 0);
      n_vec++;
      if (valid_o !== 1'b1 || rd_data_o !== 32'hF2000000 + i || tile_last_o !== (i == 3)) begin
        n_err++;
        $display("FAIL flush_after%0d got v=%b d=%h l=%b want 1 %h %b", i,
                 valid_o, rd_data_o, tile_last_o, 32'hF2000000 + i, i == 3);
      end
    end
    drive(0, '0, 0, 0);
  endtask

  task automatic test_async_reset();
    drive(0, '0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 32'hB0000000 + i, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, '0, 1, 0);
    rd_en_i = 1'b0;
    n_vec++;
    if (valid_o !== 1'b1 || tile_last_o !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pre got v=%b l=%b want 1 1", valid_o, tile_last_o);
    end
    drive(1, 32'hB0000010, 0, 0);
    wr_valid_i = 1'b0;
    rd_en_i = 1'b1;
    tick();
    #2 rst_ni = 1'b0;
    #1;
    n_vec++;
    if (valid_o !== 1'b0 || count_o !== 4'd0 || tile_last_o !== 1'b0) begin
      n_err++;
      $display("FAIL arst_async got v=%b cnt=%0d l=%b want 0 0 0",
               valid_o, count_o, tile_last_o);
    end
    rd_en_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

`ifdef WEIGHT_FIFO_ERR_EN
  task automatic test_err();
    drive(0, '0, 0, 1);
    drive(0, '0, 0, 0);
    n_vec++;
    if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear got o=%b u=%b want 0 0", overflow_o, underflow_o);
    end
    for (int i = 0; i < D; i++) drive(1, 32'hE0000000 + i, 0, 0);
    drive(1, 32'hE0000099, 0, 0);
    drive(0, '0, 0, 0);
    n_vec++;
    if (overflow_o !== 1'b1) begin
      n_err++;
      $display("FAIL err_ovf got %b want 1", overflow_o);
    end
    drive(0, '0, 0, 1);
    n_vec++;
    if (overflow_o !== 1'b0) begin
      n_err++;
      $display("FAIL err_ovf_flush got %b want 0", overflow_o);
    end
    drive(0, '0, 1, 0);
    drive(0, '0, 0, 0);
    n_vec++;
    if (underflow_o !== 1'b1) begin
      n_err++;
      $display("FAIL err_unf got %b want 1", underflow_o);
    end
    drive(0, '0, 0, 1);
    drive(0, '0, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_empty_same_cycle();
    test_back_to_back();
    test_flush();
    test_async_reset();
`ifdef WEIGHT_FIFO_ERR_EN
    test_err();
`endif
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
